// File: rtl/column_renderer.sv
// Column renderer: turns double-buffered per-column wall data into 12-bit VGA pixels.
// Ports: clk/rst, h_count/v_count/syncs in, wr_* column writes, pixel_rgb/blank_n/syncs out.
module column_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COL_SHIFT = 1,
  parameter int COLS = 320,
  parameter logic [11:0] CEIL_RGB = 12'h333,
  parameter logic [11:0] FLOOR_RGB = 12'h666
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [8:0]  wr_col,
  input  logic [8:0]  wr_height,
  input  logic [11:0] wr_rgb,
  input  logic        wr_last,
  output logic        frame_req,
  output logic [11:0] pixel_rgb,
  output logic        blank_n,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] VH = 10'(V_ACTIVE / 2);
  localparam logic [8:0] NC = 9'(COLS);

  // Each bank is 512 deep so {bank, col} forms the address directly.
  logic [20:0] mem [0:1023];

  logic        disp_sel;
  logic        pending;
  logic        disp_valid;
  logic        booted;

  logic [20:0] rd_q;
  logic [9:0]  v_q;
  logic        act_q;
  logic        hs_q;
  logic        vs_q;

  logic        xfer;
  logic        swap_pt;
  logic [8:0]  col;

  assign wr_ready = ~pending;
  assign xfer = wr_valid & wr_ready;
  assign swap_pt = (h_count == 10'd0) && (v_count == VA);
  assign col = 9'(h_count >> COL_SHIFT);

  always_ff @(posedge clk) begin
    if (xfer && (wr_col < NC))
      mem[{~disp_sel, wr_col}] <= {wr_height, wr_rgb};
    rd_q <= mem[{disp_sel, col}];
  end

  // Swap uses the registered pending, so a wr_last on the swap cycle waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_sel   <= 1'b0;
      pending    <= 1'b0;
      disp_valid <= 1'b0;
      booted     <= 1'b0;
      frame_req  <= 1'b0;
    end else begin
      booted    <= 1'b1;
      frame_req <= ~booted;
      if (swap_pt && pending) begin
        disp_sel   <= ~disp_sel;
        pending    <= 1'b0;
        disp_valid <= 1'b1;
        frame_req  <= 1'b1;
      end else if (xfer && wr_last) begin
        pending <= 1'b1;
      end
    end
  end

  logic [9:0]  half;
  logic [9:0]  top;
  logic [9:0]  sum;
  logic [9:0]  bottom;
  logic [8:0]  ht;
  logic [11:0] colour;

  always_comb begin
    ht     = rd_q[20:12];
    half   = {2'b00, ht[8:1]};
    top    = (half >= VH) ? 10'd0 : VH - half;
    sum    = VH + half;
    bottom = (sum > VA) ? VA : sum;
    colour = 12'h000;
    if (!act_q)
      colour = 12'h000;
    else if (ht == 9'd0 || !disp_valid)
      colour = (v_q < VH) ? CEIL_RGB : FLOOR_RGB;
    else if (v_q < top)
      colour = CEIL_RGB;
    else if (v_q >= bottom)
      colour = FLOOR_RGB;
    else
      colour = rd_q[11:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q       <= 10'd0;
      act_q     <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      pixel_rgb <= 12'h000;
      blank_n   <= 1'b0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      v_q       <= v_count;
      act_q     <= (h_count < HA) && (v_count < VA);
      hs_q      <= hsync_in;
      vs_q      <= vsync_in;
      pixel_rgb <= colour;
      blank_n   <= act_q;
      hsync_out <= hs_q;
      vsync_out <= vs_q;
    end
  end

endmodule

// File: tb/tb_column_renderer.sv
// Directed bench for column_renderer.
// Drives counters and column writes directly and checks pixels, syncs and handshakes.
module tb_column_renderer;

  logic        clk = 0;
  logic        rst = 1;
  logic [9:0]  h_count = 10'd1;
  logic [9:0]  v_count = 10'd0;
  logic        hsync_in = 1;
  logic        vsync_in = 1;
  logic        wr_valid = 0;
  logic        wr_ready;
  logic [8:0]  wr_col = 0;
  logic [8:0]  wr_height = 0;
  logic [11:0] wr_rgb = 0;
  logic        wr_last = 0;
  logic        frame_req;
  logic [11:0] pixel_rgb;
  logic        blank_n;
  logic        hsync_out;
  logic        vsync_out;

  int checks = 0;
  int errors = 0;

  column_renderer dut (
    .clk(clk), .rst(rst),
    .h_count(h_count), .v_count(v_count),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_col(wr_col), .wr_height(wr_height),
    .wr_rgb(wr_rgb), .wr_last(wr_last),
    .frame_req(frame_req), .pixel_rgb(pixel_rgb),
    .blank_n(blank_n), .hsync_out(hsync_out),
    .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int c, input int ht,
                    input logic [11:0] rgb, input bit last);
    @(negedge clk);
    wr_valid = 1; wr_col = 9'(c); wr_height = 9'(ht);
    wr_rgb = rgb; wr_last = last;
    @(posedge clk); #1;
    wr_valid = 0; wr_last = 0;
  endtask

  task automatic pix(input string tag, input int h, input int v,
                     input logic [11:0] exp);
    @(negedge clk);
    h_count = 10'(h); v_count = 10'(v);
    @(posedge clk);
    @(posedge clk); #1;
    chk(tag, {20'd0, pixel_rgb}, {20'd0, exp});
    h_count = 10'd1; v_count = 10'd0;
  endtask

  task automatic vblank(input string tag, input bit exp_req);
    @(negedge clk);
    h_count = 10'd0; v_count = 10'd480;
    @(posedge clk); #1;
    h_count = 10'd1; v_count = 10'd0;
    chk(tag, {31'd0, frame_req}, {31'd0, exp_req});
    @(posedge clk); #1;
    chk({tag, "_end"}, {31'd0, frame_req}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {20'd0, pixel_rgb}, 32'd0);
    chk("rst_blank", {31'd0, blank_n}, 32'd0);
    chk("rst_hs", {31'd0, hsync_out}, 32'd1);
    chk("rst_vs", {31'd0, vsync_out}, 32'd1);
    chk("rst_req", {31'd0, frame_req}, 32'd0);
    chk("rst_rdy", {31'd0, wr_ready}, 32'd1);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("boot_req", {31'd0, frame_req}, 32'd1);
    @(posedge clk); #1;
    chk("boot_req_end", {31'd0, frame_req}, 32'd0);

    pix("ceil_nodata", 20, 100, 12'h333);
    chk("blank_act", {31'd0, blank_n}, 32'd1);
    pix("floor_nodata", 20, 300, 12'h666);
    pix("h_inactive", 700, 100, 12'h000);
    chk("blank_inact", {31'd0, blank_n}, 32'd0);

    @(negedge clk); hsync_in = 0; vsync_in = 0;
    @(posedge clk); #1;
    chk("hs_d1", {31'd0, hsync_out}, 32'd1);
    chk("vs_d1", {31'd0, vsync_out}, 32'd1);
    @(negedge clk); hsync_in = 1; vsync_in = 1;
    @(posedge clk); #1;
    chk("hs_d2", {31'd0, hsync_out}, 32'd0);
    chk("vs_d2", {31'd0, vsync_out}, 32'd0);
    @(posedge clk); #1;
    chk("hs_d3", {31'd0, hsync_out}, 32'd1);

    // full frame of height 200 walls
    for (int i = 0; i < 320; i++) wr(i, 200, 12'hF00, i == 319);
    chk("rdy_pending", {31'd0, wr_ready}, 32'd0);
    pix("pre_swap", 20, 200, 12'h333);
    vblank("swap1_req", 1);
    chk("rdy_after", {31'd0, wr_ready}, 32'd1);
    pix("v139", 20, 139, 12'h333);
    pix("v140", 20, 140, 12'hF00);
    pix("v339", 20, 339, 12'hF00);
    pix("v340", 20, 340, 12'h666);
    pix("h639", 639, 200, 12'hF00);

    // tall walls on column 5
    wr(5, 480, 12'h0F0, 1);
    vblank("swap2_req", 1);
    pix("h480_top", 10, 0, 12'h0F0);
    pix("h480_bot", 11, 479, 12'h0F0);
    pix("v480_blank", 10, 480, 12'h000);
    wr(5, 511, 12'h00F, 1);
    vblank("swap3_req", 1);
    pix("h511_top", 10, 0, 12'h00F);
    pix("h511_bot", 11, 479, 12'h00F);
    pix("old_col", 20, 200, 12'hF00);

    // blocked writes while pending
    wr(7, 0, 12'h0FF, 1);
    chk("rdy_blocked", {31'd0, wr_ready}, 32'd0);
    wr(7, 200, 12'h0FF, 0);
    vblank("swap4_req", 1);
    pix("ignored_wr", 14, 200, 12'h333);
    pix("h0_floor", 14, 300, 12'h666);
    vblank("noswap_req", 0);
    pix("noswap_pix", 14, 200, 12'h333);

    // wr_last on the swap-point cycle
    @(negedge clk);
    h_count = 10'd0; v_count = 10'd480;
    wr_valid = 1; wr_col = 9'd7; wr_height = 9'd200;
    wr_rgb = 12'h0FF; wr_last = 1;
    @(posedge clk); #1;
    wr_valid = 0; wr_last = 0;
    h_count = 10'd1; v_count = 10'd0;
    chk("sp_last_req", {31'd0, frame_req}, 32'd0);
    chk("sp_last_rdy", {31'd0, wr_ready}, 32'd0);
    pix("sp_last_pix", 14, 200, 12'h333);
    vblank("swap5_req", 1);
    pix("sp_swap_pix", 14, 200, 12'h0FF);

    // out-of-range column
    wr(400, 0, 12'h000, 0);
    chk("oor_rdy", {31'd0, wr_ready}, 32'd1);
    pix("oor_pix", 14, 200, 12'h0FF);

    // reset mid-line
    @(negedge clk); h_count = 10'd20; v_count = 10'd200;
    @(posedge clk);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    chk("mid_rgb", {20'd0, pixel_rgb}, 32'd0);
    chk("mid_blank", {31'd0, blank_n}, 32'd0);
    chk("mid_rdy", {31'd0, wr_ready}, 32'd1);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("mid_boot_req", {31'd0, frame_req}, 32'd1);
    pix("mid_invalid", 20, 200, 12'h333);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
